seg7_scan_mux: RTL and testbench
================================

// Module: seg7_scan_mux
// PURPOSE
//  Parametrised 7-segment scan driver: N_DIGITS-digit multiplexed hex display fed from N_CH selectable data channels.
//  Sits in the board top between the CPU debug taps (register, PC, instruction, ...) and the board LED pins.
//  Adds frame-coherent latching, channel select, freeze, per-digit decimal point, leading-zero blanking and pin polarity.
// PARAMETERS
//  N_DIGITS    8   digits scanned; data width per channel = 4*N_DIGITS
//  N_CH        4   number of input channels (>=1)
//  DIV_W       14  refresh divider width; one digit slot = 2**DIV_W clk cycles
//  ACTIVE_LOW  1   1: o_seg/o_sel active-low pins; 0: both active-high
// PORTS
//  clk         in   1                     system clock, single domain
//  rst         in   1                     synchronous, active-high reset
//  cs          in   1                     display enable; 0 = shadow not reloaded and all digits dark
//  i_ch_data   in   N_CH*4*N_DIGITS       channel c = i_ch_data[c*4*N_DIGITS +: 4*N_DIGITS]
//  i_sel       in   max(1,$clog2(N_CH))   channel select; values >= N_CH select channel 0
//  i_freeze    in   1                     1 = hold shadow (no reload at frame boundary)
//  i_dp        in   N_DIGITS              decimal point on for digit k when i_dp[k]=1
//  i_blank_lz  in   1                     leading-zero blanking enable
//  o_seg       out  8                     {dp,g,f,e,d,c,b,a}
//  o_sel       out  N_DIGITS              one-hot digit strobe, digit 0 = least significant nibble
// BEHAVIOUR
//  Clock and reset: one clock domain, clk; reset rst is synchronous and active-high.
//  - Divider div (DIV_W bits) increments every clk and wraps; tick = (div == all ones).
//  - Digit index idx advances on tick; wraps N_DIGITS-1 -> 0. Frame boundary = tick && idx==N_DIGITS-1.
//  - Shadow reg (4*N_DIGITS) loads the selected channel at a frame boundary iff cs && !i_freeze; otherwise it holds.
//    Changes to i_sel or i_ch_data mid-frame never tear the display; they show from the next frame.
//  - Outputs registered every clk from (idx, shadow, i_dp, i_blank_lz, cs): 1-cycle latency from idx/shadow change.
//  - Nibble decode, active-low form (logical 1 = segment off): 0 C0,1 F9,2 A4,3 B0,4 99,5 92,6 82,7 F8,
//    8 80,9 90,A 88,b 83,C C6,d A1,E 86,F 8E; dp on clears bit7; blank = FF.
//  - Leading-zero blanking: digit k (k>0) is blank when i_blank_lz=1 and all shadow nibbles k..N_DIGITS-1 are 0.
//    Digit 0 is never blanked by LZ; a blanked digit also suppresses its dp.
//  - cs=0: o_sel all off, o_seg blank; div/idx keep running.
//  - ACTIVE_LOW=1: o_sel = ~onehot(idx); ACTIVE_LOW=0: o_seg and o_sel both inverted relative to the above.
//  - Reset (anytime, incl. mid-frame): div=0, idx=0, shadow=0, o_seg=blank, o_sel=all off
//    (FF.., i.e. all ones, for ACTIVE_LOW=1). The first cycle after release registers digit 0 of shadow 0.
//  - A tick coinciding with rst: reset wins. A frame boundary with i_freeze=1 and cs=1: shadow holds, scan continues.
// STRUCTURE
//  - Package seg7_pkg: 16-entry segment LUT constants, SEG_BLANK, function hex_to_seg(nibble, dp).
//  - Sub-module seg7_decode (combinational nibble+dp+blank -> 8-bit active-low segments); polarity applied in parent.
//  - Parent holds divider, idx counter, shadow, LZ prefix mask, output registers.
// TESTING  (DIV_W=2, N_DIGITS=8, N_CH=4, ACTIVE_LOW=1 unless noted)
//  1 rst=1 for 3 cycles mid-scan -> o_seg=FF, o_sel=FF; after release -> o_sel=FE, o_seg=C0; o_sel steps FD,FB..7F every 4 clk.
//  2 ch1=32'h1234ABCD, i_sel=1, cs=1, after 1 frame boundary -> digit0 A1, digit3 88, digit4 99, digit7 F9.
//  3 i_blank_lz=1, selected data 32'h000000A5 -> digits 7..2 FF, digit1 88, digit0 92; data 0 -> only digit0 C0.
//  4 switch i_sel 1->2 mid-frame -> rest of frame shows ch1; next frame ch2. i_freeze=1 -> ch2 held across new data.
//  5 i_dp=8'h04, data 0x...3.. at digit2 -> digit2 o_seg=30 (B0 with bit7 cleared); other digits unchanged; cs=0 -> FF/FF.
//  6 ACTIVE_LOW=0 build, data 32'h00000008 -> digit0 o_sel=01, o_seg=7F; reset -> o_seg=00, o_sel=00.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan driver.
// Segment patterns are active-low {dp,g,f,e,d,c,b,a}: logical 1 = segment off.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Index 0 sits in the low byte, so the list reads F down to 0.
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // A lit decimal point clears bit 7 (active-low).
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib, input logic dp);
    logic [7:0] s;
    s = SEG_LUT[nib];
    if (dp) s[7] = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Display-side bundle: channel data and controls in, pin-level segment/strobe out.
interface seg7_scan_mux_if #(
  parameter int N_DIGITS = 8,
  parameter int N_CH     = 4
);
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                       cs;
  logic [N_CH*4*N_DIGITS-1:0] i_ch_data;
  logic [SEL_W-1:0]           i_sel;
  logic                       i_freeze;
  logic [N_DIGITS-1:0]        i_dp;
  logic                       i_blank_lz;
  logic [7:0]                 o_seg;
  logic [N_DIGITS-1:0]        o_sel;

  modport master (
    output cs, i_ch_data, i_sel, i_freeze, i_dp, i_blank_lz,
    input  o_seg, o_sel
  );

  modport slave (
    input  cs, i_ch_data, i_sel, i_freeze, i_dp, i_blank_lz,
    output o_seg, o_sel
  );
endinterface

// File: rtl/seg7_decode.sv
// One digit: nibble + dp + blank -> active-low segment pattern.
// Polarity for the pins is applied by the parent.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  // Blanking overrides the digit and its decimal point.
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) seg_o = hex_to_seg(nib_i, dp_i);
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed hex display driver: refresh divider, digit scan, frame-coherent
// shadow of the selected channel, leading-zero blanking and pin polarity.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int N_DIGITS   = 8,
  parameter int N_CH       = 4,
  parameter int DIV_W      = 14,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  seg7_scan_mux_if.slave  bus
);

  localparam int                  DATA_W   = 4 * N_DIGITS;
  localparam int                  IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [7:0]          SEG_RST  = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
  localparam logic [N_DIGITS-1:0] SEL_OFF  = ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  logic [DIV_W-1:0]               div_q, div_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [N_DIGITS-1:0][3:0]       shadow_q, shadow_d;
  logic [7:0]                     seg_q, seg_d;
  logic [N_DIGITS-1:0]            sel_q, sel_d;

  logic                           tick, frame;
  logic [DATA_W-1:0]              ch_data;
  logic [N_DIGITS-1:0]            lz_blank;
  logic [N_DIGITS-1:0][7:0]       dig_seg;

  assign tick  = &div_q;
  assign frame = tick && (idx_q == IDX_LAST);

  // Channel mux; out-of-range selects fall through to channel 0.
  always_comb begin
    ch_data = bus.i_ch_data[0 +: DATA_W];
    for (int c = 1; c < N_CH; c++)
      if (int'(bus.i_sel) == c) ch_data = bus.i_ch_data[c*DATA_W +: DATA_W];
  end

  // Divider, scan index and shadow next state; shadow only moves at a frame boundary.
  always_comb begin
    div_d    = div_q + 1'b1;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    if (frame && bus.cs && !bus.i_freeze) shadow_d = ch_data;
  end

  // Scan state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  // Leading-zero mask: walk from the top digit down, blank while everything above is zero.
  always_comb begin
    logic nz_seen;
    nz_seen  = 1'b0;
    lz_blank = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      nz_seen     = nz_seen | (shadow_q[k] != 4'h0);
      lz_blank[k] = bus.i_blank_lz && (k != 0) && !nz_seen;
    end
  end

  // Decoder per digit; the scan index picks one below.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
    seg7_decode u_dec (
      .nib_i   (shadow_q[g]),
      .dp_i    (bus.i_dp[g]),
      .blank_i (lz_blank[g]),
      .seg_o   (dig_seg[g])
    );
  end

  // Pin values: active-low form first, then flipped for active-high boards.
  always_comb begin
    seg_d = SEG_BLANK;
    sel_d = '1;
    if (bus.cs) begin
      seg_d        = dig_seg[idx_q];
      sel_d[idx_q] = 1'b0;
    end
    if (!ACTIVE_LOW) begin
      seg_d = ~seg_d;
      sel_d = ~sel_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_RST;
      sel_q <= SEL_OFF;
    end else begin
      seg_q <= seg_d;
      sel_q <= sel_d;
    end
  end

  assign bus.o_seg = seg_q;
  assign bus.o_sel = sel_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: an active-low and an active-high instance share stimulus
// and are checked every cycle against a cycle-count based model, plus directed vectors.
module tb_seg7_scan_mux;

  logic             clk = 1'b0;
  logic             rst;
  logic             cs;
  logic [3:0][31:0] ch;
  logic [1:0]       sel;
  logic             freeze;
  logic [7:0]       dp;
  logic             blz;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_mux_if #(.N_DIGITS(8), .N_CH(4)) ifa ();
  seg7_scan_mux_if #(.N_DIGITS(8), .N_CH(4)) ifb ();

  assign ifa.cs = cs;  assign ifa.i_ch_data = ch;  assign ifa.i_sel = sel;
  assign ifa.i_freeze = freeze;  assign ifa.i_dp = dp;  assign ifa.i_blank_lz = blz;
  assign ifb.cs = cs;  assign ifb.i_ch_data = ch;  assign ifb.i_sel = sel;
  assign ifb.i_freeze = freeze;  assign ifb.i_dp = dp;  assign ifb.i_blank_lz = blz;

  seg7_scan_mux #(.N_DIGITS(8), .N_CH(4), .DIV_W(2), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  seg7_scan_mux #(.N_DIGITS(8), .N_CH(4), .DIV_W(2), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  // Segment patterns straight from the digit table (active-low).
  logic [7:0] lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model state: clocks since reset release and the latched word.
  int          m_cnt = 0;
  logic [31:0] m_shadow = '0;
  logic [7:0]  m_seg, m_sel;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: predict registered outputs from pre-edge state, advance model, compare both DUTs.
  task automatic cyc();
    logic [7:0] es, eq;
    logic [3:0] nib;
    logic       blank;
    int         k;
    es = 8'hFF;
    eq = 8'hFF;
    if (!rst && cs) begin
      k     = (m_cnt / 4) % 8;
      nib   = 4'((m_shadow >> (4 * k)) & 32'hF);
      blank = blz && (k > 0) && ((m_shadow >> (4 * k)) == 32'h0);
      es    = blank ? 8'hFF : (lut[nib] & (dp[k] ? 8'h7F : 8'hFF));
      eq    = ~(8'(1) << k);
    end
    if (rst) begin
      m_cnt    = 0;
      m_shadow = '0;
    end else begin
      if ((m_cnt % 32) == 31 && cs && !freeze) m_shadow = ch[sel];
      m_cnt++;
    end
    @(posedge clk);
    #1;
    m_seg = es;
    m_sel = eq;
    chk("model_seg_al", ifa.o_seg, es);
    chk("model_sel_al", ifa.o_sel, eq);
    chk("model_seg_ah", ifb.o_seg, ~es);
    chk("model_sel_ah", ifb.o_sel, ~eq);
  endtask

  // Clock until the displayed strobe is digit k (bounded).
  task automatic run_to_digit(input int k);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 64 && !found; n++) begin
      cyc();
      if (m_sel == ~(8'(1) << k)) found = 1'b1;
    end
    if (!found) begin
      n_chk++;
      n_err++;
      $display("FAIL run_to_digit: digit %0d not reached within 64 cycles", k);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        blz;
    logic [7:0]  dp;
    int          k;
    logic [7:0]  exp_seg;
  } vec_t;

  vec_t vecs [15];

  initial begin
    vecs[0]  = '{32'h1234ABCD, 1'b0, 8'h00, 0, 8'hA1};
    vecs[1]  = '{32'h1234ABCD, 1'b0, 8'h00, 3, 8'h88};
    vecs[2]  = '{32'h1234ABCD, 1'b0, 8'h00, 4, 8'h99};
    vecs[3]  = '{32'h1234ABCD, 1'b0, 8'h00, 7, 8'hF9};
    vecs[4]  = '{32'h000000A5, 1'b1, 8'h00, 7, 8'hFF};
    vecs[5]  = '{32'h000000A5, 1'b1, 8'h00, 2, 8'hFF};
    vecs[6]  = '{32'h000000A5, 1'b1, 8'h00, 1, 8'h88};
    vecs[7]  = '{32'h000000A5, 1'b1, 8'h00, 0, 8'h92};
    vecs[8]  = '{32'h00000000, 1'b1, 8'h00, 0, 8'hC0};
    vecs[9]  = '{32'h00000000, 1'b1, 8'h00, 1, 8'hFF};
    vecs[10] = '{32'h00000300, 1'b0, 8'h04, 2, 8'h30};
    vecs[11] = '{32'h00000300, 1'b0, 8'h04, 1, 8'hC0};
    vecs[12] = '{32'h00000005, 1'b1, 8'h80, 7, 8'hFF};
    vecs[13] = '{32'h00000008, 1'b0, 8'h00, 0, 8'h80};
    vecs[14] = '{32'h00000000, 1'b0, 8'h00, 5, 8'hC0};

    rst = 1'b1; cs = 1'b1; ch = '0; sel = 2'd1; freeze = 1'b0; dp = '0; blz = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (13) cyc();

    // Reset mid-scan, then the strobe walks digit by digit.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_seg_al", ifa.o_seg, 8'hFF);
      chk("rst_sel_al", ifa.o_sel, 8'hFF);
      chk("rst_seg_ah", ifb.o_seg, 8'h00);
      chk("rst_sel_ah", ifb.o_sel, 8'h00);
    end
    rst = 1'b0;
    cyc();
    chk("rel_sel", ifa.o_sel, 8'hFE);
    chk("rel_seg", ifa.o_seg, 8'hC0);
    for (int d = 1; d < 8; d++) begin
      logic [7:0] e;
      e = ~(8'(1) << d);
      repeat (4) cyc();
      chk($sformatf("step_sel%0d", d), ifa.o_sel, e);
    end

    // Table vectors on channel 1.
    sel = 2'd1;
    for (int i = 0; i < 15; i++) begin
      ch[1] = vecs[i].data;
      blz   = vecs[i].blz;
      dp    = vecs[i].dp;
      repeat (36) cyc();
      run_to_digit(vecs[i].k);
      chk($sformatf("vec%0d_seg_al", i), ifa.o_seg, vecs[i].exp_seg);
      chk($sformatf("vec%0d_seg_ah", i), ifb.o_seg, ~vecs[i].exp_seg);
      chk($sformatf("vec%0d_sel_ah", i), ifb.o_sel, 8'(1) << vecs[i].k);
    end
    blz = 1'b0; dp = '0;

    // Mid-frame select change shows only from the next frame; freeze holds it.
    ch[1] = 32'h1234ABCD;
    ch[2] = 32'h90000000;
    repeat (40) cyc();
    run_to_digit(1);
    sel = 2'd2;
    run_to_digit(7);
    chk("midframe_old", ifa.o_seg, 8'hF9);
    run_to_digit(0);
    run_to_digit(7);
    chk("nextframe_new", ifa.o_seg, 8'h90);
    freeze = 1'b1;
    ch[2]  = 32'h70000000;
    repeat (70) cyc();
    run_to_digit(7);
    chk("freeze_hold", ifa.o_seg, 8'h90);
    freeze = 1'b0;
    repeat (36) cyc();
    run_to_digit(7);
    chk("unfreeze_load", ifa.o_seg, 8'hF8);

    // Display disabled: dark on both polarities.
    cs = 1'b0;
    repeat (2) cyc();
    chk("cs0_seg_al", ifa.o_seg, 8'hFF);
    chk("cs0_sel_al", ifa.o_sel, 8'hFF);
    chk("cs0_seg_ah", ifb.o_seg, 8'h00);
    chk("cs0_sel_ah", ifb.o_sel, 8'h00);
    cs = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rst    = ($urandom_range(0, 99) == 0);
      cs     = ($urandom_range(0, 7) != 0);
      freeze = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) ch[$urandom_range(0, 3)] = $urandom >> (4 * $urandom_range(0, 8));
      if ($urandom_range(0, 31) == 0) dp = 8'($urandom);
      if ($urandom_range(0, 31) == 0) blz = 1'($urandom);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
